beta_regfile: RTL and testbench

Parametrised register file for the Beta-style RISC datapath, generalising the original 32×32 regfile in data width and register count. Two combinational read ports and one synchronous write port, hardwired zero register, XP-select on the write address and RC-select on read port 2. After reset a clear sequencer zeroes every register one entry per cycle before the file accepts writes, so the array maps to inferred RAM rather than per-bit resettable flops. Sits between the decode stage (addresses, selects) and the ALU/writeback mux.

---
 rtl/beta_regfile.sv | 84 ++++++++
 tb/tb_beta_regfile.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/beta_regfile.sv
// beta_regfile: parametrised Beta register file, 2 comb read ports, 1 sync write port, post-reset clear sequencer.
// Optional same-cycle write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module beta_regfile #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 5,
    parameter int XP_ADDR   = 30,
    parameter int ZERO_ADDR = 2**ADDR_W-1
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic [ADDR_W-1:0] ra_i,
    input  logic [ADDR_W-1:0] rb_i,
    input  logic [ADDR_W-1:0] rc_i,
    input  logic              ra2sel_i,
    input  logic              wasel_i,
    input  logic              werf_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] radata_o,
    output logic [DATA_W-1:0] rbdata_o,
    output logic              ready_o
);
    localparam int NREGS = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] ZA   = ADDR_W'(ZERO_ADDR);
    localparam logic [ADDR_W-1:0] XA   = ADDR_W'(XP_ADDR);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NREGS-1);

    typedef enum logic {CLEAR, READY} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [DATA_W-1:0] mem_q [NREGS];
    logic              clearing;
    logic [ADDR_W-1:0] ra2, wa, mem_addr;
    logic              wr_en, fwd_a, fwd_b;

    assign ra2 = ra2sel_i ? rc_i : rb_i;
    assign wa  = wasel_i ? XA : rc_i;

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= CLEAR;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        if (state_q == CLEAR) begin
            state_d = (idx_q == LAST) ? READY : CLEAR;
            idx_d   = (idx_q == LAST) ? idx_q : idx_q + 1'b1;
        end
    end

    always_comb begin
        clearing = state_q == CLEAR;
        ready_o  = state_q == READY;
    end

    // Single write port shared by the clear sequencer and user writes, so the array stays RAM-inferable.
    assign wr_en    = ready_o && werf_i && (wa != ZA);
    assign mem_addr = clearing ? idx_q : wa;

    always_ff @(posedge clock_i) begin
        if (clearing || wr_en)
            mem_q[mem_addr] <= clearing ? '0 : wdata_i;
    end

`ifdef REGFILE_BYPASS_EN
    assign fwd_a = wr_en && (wa == ra_i);
    assign fwd_b = wr_en && (wa == ra2);
`else
    assign fwd_a = 1'b0;
    assign fwd_b = 1'b0;
`endif

    always_comb begin
        radata_o = (clearing || ra_i == ZA) ? '0 : fwd_a ? wdata_i : mem_q[ra_i];
        rbdata_o = (clearing || ra2 == ZA) ? '0 : fwd_b ? wdata_i : mem_q[ra2];
    end
endmodule

// File: tb/tb_beta_regfile.sv
// tb_beta_regfile: randomized + directed checks of beta_regfile against an array-based reference model.
module tb_beta_regfile;
    logic        clk = 0, rst = 1;
    logic [4:0]  ra = 0, rb = 0, rc = 0;
    logic        ra2sel = 0, wasel = 0, werf = 0;
    logic [31:0] wdata = 0, radata, rbdata;
    logic        ready;
    int          checks = 0, errors = 0;
    logic [31:0] mdl [32];
    int          clr_cnt = 0;
    bit          mrdy = 0;

    beta_regfile dut (
        .clock_i(clk), .reset_i(rst), .ra_i(ra), .rb_i(rb), .rc_i(rc),
        .ra2sel_i(ra2sel), .wasel_i(wasel), .werf_i(werf), .wdata_i(wdata),
        .radata_o(radata), .rbdata_o(rbdata), .ready_o(ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [4:0] cur_wa();
        return wasel ? 5'd30 : rc;
    endfunction

    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        if (!mrdy || a == 5'd31) return 0;
`ifdef REGFILE_BYPASS_EN
        if (werf && cur_wa() == a && a != 5'd31) return wdata;
`endif
        return mdl[a];
    endfunction

    task automatic check_ports(input string tag);
        chk({tag, ":ready"}, {31'b0, ready}, {31'b0, mrdy});
        chk({tag, ":ra"}, radata, exp_rd(ra));
        chk({tag, ":rb"}, rbdata, exp_rd(ra2sel ? rc : rb));
    endtask

    // Model: the file is unusable for NREGS edges after reset, then every entry is zero.
    task automatic tick();
        if (!mrdy) begin
            clr_cnt++;
            if (clr_cnt == 32) begin
                mrdy = 1;
                foreach (mdl[i]) mdl[i] = 0;
            end
        end else if (werf && cur_wa() != 5'd31) begin
            mdl[cur_wa()] = wdata;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1;
        mrdy = 0;
        clr_cnt = 0;
        #2;
        check_ports("reset");
        rst = 0;
    endtask

    task automatic read_all(input string tag);
        werf = 0; ra2sel = 0;
        for (int a = 0; a < 32; a++) begin
            ra = 5'(a); rb = 5'(31 - a);
            #1;
            check_ports(tag);
        end
    endtask

    task automatic wr(input logic [4:0] r, input logic xp, input logic [31:0] d);
        rc = r; wasel = xp; wdata = d; werf = 1;
        tick();
        werf = 0; wasel = 0;
    endtask

    initial begin
        @(posedge clk); #1;
        do_reset();
        for (int e = 1; e <= 31; e++) begin
            ra = 5'($urandom); rb = 5'($urandom); werf = 1'($urandom); wdata = $urandom;
            tick();
            check_ports("clear_idle");
        end
        werf = 0;
        tick();
        chk("ready_after_32", {31'b0, ready}, 32'd1);
        read_all("all_zero");

        wr(5'd5, 0, 32'hDEADBEEF);
        ra = 5; ra2sel = 1; rc = 5; #1;
        chk("ra5", radata, 32'hDEADBEEF);
        chk("rc5", rbdata, 32'hDEADBEEF);
        ra2sel = 0; rb = 5; #1;
        chk("rb5", rbdata, 32'hDEADBEEF);

        wr(5'd0, 1, 32'h12345678);
        wr(5'd31, 0, 32'hFFFFFFFF);
        ra = 30; rb = 31; ra2sel = 0; #1;
        chk("xp30", radata, 32'h12345678);
        chk("zero31", rbdata, 32'h0);

        wr(5'd7, 0, 32'h11111111);
        rc = 7; wdata = 32'h22222222; werf = 1; ra = 7; #1;
`ifdef REGFILE_BYPASS_EN
        chk("same_cycle_pre", radata, 32'h22222222);
`else
        chk("same_cycle_pre", radata, 32'h11111111);
`endif
        tick();
        werf = 0; #1;
        chk("same_cycle_post", radata, 32'h22222222);

        do_reset();
        for (int e = 1; e <= 32; e++) begin
            werf = (e <= 10); rc = 3; wdata = 32'hA5A5A5A5; ra = 3;
            tick();
            check_ports("clear_wr");
        end
        werf = 0; ra = 3; #1;
        chk("reg3_zero", radata, 32'h0);

        do_reset();
        for (int e = 1; e <= 20; e++) tick();
        do_reset();
        for (int e = 1; e <= 31; e++) begin
            tick();
            chk("restart_ready0", {31'b0, ready}, 32'd0);
        end
        tick();
        chk("restart_ready1", {31'b0, ready}, 32'd1);

        for (int n = 0; n < 400; n++) begin
            ra = 5'($urandom); rb = 5'($urandom); rc = 5'($urandom);
            ra2sel = 1'($urandom); wasel = ($urandom_range(0, 7) == 0);
            werf = 1'($urandom); wdata = $urandom;
            if ($urandom_range(0, 3) == 0) ra = cur_wa();
            #1;
            check_ports("rand");
            tick();
        end
        werf = 0;
        read_all("rand_final");

        wr(5'd9, 0, 32'hCAFEF00D);
        ra = 9; #1;
        chk("reg9_set", radata, 32'hCAFEF00D);
        do_reset();
        for (int e = 1; e <= 32; e++) tick();
        ra = 9; #1;
        chk("reg9_cleared", radata, 32'h0);
        chk("ready_final", {31'b0, ready}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
